// File: rtl/gcd_seq_ctrl.sv
// Subtractive-Euclid GCD engine: start-edge capture, one compare/subtract step
// per enabled clock, sticky done/err until acknowledged or restarted.
module gcd_seq_ctrl #(
    parameter int unsigned W  = 8,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_en,
    input  logic          start,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    input  logic          ack,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic [CW-1:0] iter_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e        state_q,      state_d;
    logic [W-1:0]  a_q,          a_d;
    logic [W-1:0]  b_q,          b_d;
    logic [W-1:0]  result_q,     result_d;
    logic [CW-1:0] iter_q,       iter_d;
    logic          err_q,        err_d;
    logic          start_prev_q, start_prev_d;

    logic          start_edge;
    logic [CW-1:0] iter_inc;

    assign start_edge = start & ~start_prev_q;
    assign iter_inc   = (iter_q == {CW{1'b1}}) ? iter_q : iter_q + CW'(1);

    // NOTE: every next-state variable is defaulted to its current value first,
    // so no path through the case statement can leave one unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        result_d     = result_q;
        iter_d       = iter_q;
        err_d        = err_q;
        start_prev_d = start_prev_q;

        if (clk_en) begin
            start_prev_d = start;
            case (state_q)
                S_IDLE: begin
                    if (start_edge) begin
                        a_d     = a_in;
                        b_d     = b_in;
                        iter_d  = '0;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    if (a_q == '0 && b_q == '0) begin
                        result_d = '0;
                        err_d    = 1'b1;
                        state_d  = S_DONE;
                    end else if (a_q == '0) begin
                        result_d = b_q;
                        state_d  = S_DONE;
                    end else if (b_q == '0 || a_q == b_q) begin
                        result_d = a_q;
                        state_d  = S_DONE;
                    end else if (a_q > b_q) begin
                        a_d    = a_q - b_q;
                        iter_d = iter_inc;
                    end else begin
                        b_d    = b_q - a_q;
                        iter_d = iter_inc;
                    end
                end
                S_DONE: begin
                    // A new start outranks a simultaneous ack.
                    if (start_edge) begin
                        a_d     = a_in;
                        b_d     = b_in;
                        iter_d  = '0;
                        err_d   = 1'b0;
                        state_d = S_CALC;
                    end else if (ack) begin
                        err_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update
    // from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            result_q     <= '0;
            iter_q       <= '0;
            err_q        <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            result_q     <= result_d;
            iter_q       <= iter_d;
            err_q        <= err_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign busy       = (state_q == S_CALC);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign result     = result_q;
    assign iter_count = iter_q;

endmodule
